// File: rtl/spi_slave_sync.sv
// spi_slave_sync: core-clock SPI slave with burst register access; define SPI_SLAVE_FETCH_EN to enable the FETCH opcode
module spi_slave_sync #(
  parameter int DW = 8,
  parameter int AW = DW - 2,
  parameter int SYNC = 2
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          sclk,
  input  logic          mosi,
  input  logic          ss,
  output logic          miso,
  input  logic          spi_en,
  input  logic          cpol,
  input  logic          cpha,
  input  logic          lsbfirst,
  output logic          reg_write,
  output logic          reg_read,
  output logic [AW-1:0] reg_addr,
  output logic [DW-1:0] reg_wdata,
  input  logic [DW-1:0] reg_rdata,
  output logic          access_out,
  output logic [AW-1:0] fetch_addr,
  input  logic          wait_in,
  output logic          frame_err
);
  localparam int CW = $clog2(DW);
  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b10;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state;
  logic [SYNC-1:0] sclk_s, ss_s, mosi_s;
  logic sclk_q, sclk_qq, ss_q, ss_qq, mosi_q;
  logic [CW-1:0] bit_cnt;
  logic [DW-1:0] rx, tx, rx_next, tx_next;
  logic [1:0] op;
  logic [AW-1:0] addr;
  logic miso_r, rd_pend;
  logic sclk_rise, sclk_fall, ss_rise, ss_fall, sample, drive, last, tx_bit;
  assign sclk_rise = sclk_q & ~sclk_qq;
  assign sclk_fall = ~sclk_q & sclk_qq;
  assign ss_rise = ss_q & ~ss_qq;
  assign ss_fall = ~ss_q & ss_qq;
  assign sample = (cpol ^ cpha) ? sclk_fall : sclk_rise;
  assign drive = (cpol ^ cpha) ? sclk_rise : sclk_fall;
  assign last = bit_cnt == CW'(DW - 1);
  assign rx_next = lsbfirst ? {mosi_q, rx[DW-1:1]} : {rx[DW-2:0], mosi_q};
  assign tx_next = lsbfirst ? {1'b0, tx[DW-1:1]} : {tx[DW-2:0], 1'b0};
  assign tx_bit = lsbfirst ? tx[0] : tx[DW-1];
  assign miso = miso_r & spi_en & ~ss_q;
  // pin synchronizers plus one extra stage used for edge detection
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      sclk_s <= '0;
      ss_s <= '0;
      mosi_s <= '0;
      sclk_q <= 1'b0;
      sclk_qq <= 1'b0;
      ss_q <= 1'b0;
      ss_qq <= 1'b0;
      mosi_q <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[SYNC-2:0], sclk};
      ss_s <= {ss_s[SYNC-2:0], ss};
      mosi_s <= {mosi_s[SYNC-2:0], mosi};
      sclk_q <= sclk_s[SYNC-1];
      sclk_qq <= sclk_q;
      ss_q <= ss_s[SYNC-1];
      ss_qq <= ss_q;
      mosi_q <= mosi_s[SYNC-1];
    end
  // frame FSM: shifts bits, decodes the command word and issues register strobes
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      state <= IDLE;
      bit_cnt <= '0;
      rx <= '0;
      tx <= '0;
      miso_r <= 1'b0;
      op <= OP_WR;
      addr <= '0;
      rd_pend <= 1'b0;
      reg_write <= 1'b0;
      reg_read <= 1'b0;
      reg_addr <= '0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      reg_read <= 1'b0;
      frame_err <= 1'b0;
      rd_pend <= reg_read;
      if (!spi_en) begin
        state <= IDLE;
        bit_cnt <= '0;
        miso_r <= 1'b0;
      end else if (state == IDLE) begin
        miso_r <= 1'b0;
        if (ss_fall) begin
          state <= CMD;
          bit_cnt <= '0;
          tx <= '0;
        end
      end else if (ss_rise) begin
        state <= IDLE;
        miso_r <= 1'b0;
        frame_err <= bit_cnt != '0;
      end else begin
        if (drive) begin
          miso_r <= tx_bit;
          tx <= tx_next;
        end
        if (rd_pend) tx <= reg_rdata;
        if (sample) begin
          rx <= rx_next;
          bit_cnt <= bit_cnt + 1'b1;
          if (last && state == CMD) begin
            state <= DATA;
            op <= rx_next[DW-1:DW-2];
            addr <= rx_next[AW-1:0];
            reg_addr <= rx_next[AW-1:0];
            reg_read <= rx_next[DW-1:DW-2] == OP_RD;
          end else if (last && op == OP_WR) begin
            reg_write <= 1'b1;
            reg_wdata <= rx_next;
            reg_addr <= addr;
            addr <= addr + 1'b1;
          end else if (last && op == OP_RD) begin
            reg_read <= 1'b1;
            reg_addr <= addr + 1'b1;
            addr <= addr + 1'b1;
          end
        end
      end
    end
`ifdef SPI_SLAVE_FETCH_EN
  logic fetch_req;
  assign fetch_req = spi_en & ss_rise & (state == DATA) & (op == 2'b11);
  // fetch request: held while wait_in, a new one is dropped while pending
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      access_out <= 1'b0;
      fetch_addr <= '0;
    end else if (access_out) begin
      access_out <= wait_in;
    end else if (fetch_req) begin
      access_out <= 1'b1;
      fetch_addr <= addr;
    end
`else
  logic unused_fetch;
  assign unused_fetch = &{1'b0, wait_in};
  assign access_out = 1'b0;
  assign fetch_addr = '0;
`endif
endmodule

// File: tb/tb_spi_slave_sync.sv
// tb_spi_slave_sync: randomized SPI master with scoreboard of expected register/fetch/error events
module tb_spi_slave_sync;
  localparam int HALF = 6;
  localparam int SETUP = 6;
  localparam int GAP = 30;
  logic clk = 1'b0;
  logic nreset, sclk, mosi, ss, miso, spi_en, cpol, cpha, lsbfirst;
  logic reg_write, reg_read, access_out, wait_in, frame_err;
  logic [5:0] reg_addr, fetch_addr, fa_prev;
  logic [7:0] reg_wdata, reg_rdata;
  logic acc_prev = 1'b0;
  logic acc_seen = 1'b0;
  logic [7:0] fb [0:7];
  typedef struct {int kind; int addr; int data;} ev_t;
  ev_t exp_q[$];
  int checks = 0;
  int passes = 0;

  spi_slave_sync dut (
    .clk(clk), .nreset(nreset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .spi_en(spi_en), .cpol(cpol), .cpha(cpha), .lsbfirst(lsbfirst),
    .reg_write(reg_write), .reg_read(reg_read), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .access_out(access_out),
    .fetch_addr(fetch_addr), .wait_in(wait_in), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  assign reg_rdata = {2'b00, reg_addr} + 8'h40;

  function automatic int rd_model(int a);
    return (a & 63) + 64;
  endfunction

  function automatic int outs();
    return {7'b0, miso, reg_write, reg_read, reg_addr, reg_wdata, access_out, fetch_addr, frame_err};
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic push(input int k, input int a, input int d);
    ev_t e;
    e.kind = k;
    e.addr = a & 63;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int k, input int a, input int d);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", k, -1);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", k, e.kind);
    check("event_addr", a, e.addr);
    check("event_data", d, e.data);
  endtask

  task automatic set_mode(input int m, input bit lsb);
    cpol = m[1];
    cpha = m[0];
    lsbfirst = lsb;
    sclk = cpol;
    repeat (GAP) @(negedge clk);
  endtask

  // nw complete words from fb (fb[0] = command), then pb bits of fb[nw]
  task automatic spi_xfer(input int nw, input int pb, input bit do_rst);
    logic [7:0] got;
    int op, a;
    op = fb[0][7:6];
    a = fb[0][5:0];
    if (spi_en && nw > 0) begin
      if (op == 0) for (int k = 1; k < nw; k++) push(0, a + k - 1, fb[k]);
      if (op == 2) for (int k = 0; k < nw; k++) push(1, a + k, 0);
    end
    if (spi_en && pb > 0 && !do_rst) push(2, 0, 0);
`ifdef SPI_SLAVE_FETCH_EN
    if (spi_en && nw > 0 && op == 3 && !do_rst) push(3, a, 0);
`endif
    ss = 1'b0;
    repeat (SETUP) @(negedge clk);
    for (int w = 0; w <= nw; w++) begin
      int nb = (w < nw) ? 8 : pb;
      got = 8'h00;
      for (int i = 0; i < nb; i++) begin
        int bi = lsbfirst ? i : 7 - i;
        if (cpha) sclk = ~sclk;
        mosi = fb[w][bi];
        repeat (HALF) @(negedge clk);
        got[bi] = miso;
        sclk = ~sclk;
        repeat (HALF) @(negedge clk);
        if (!cpha) sclk = ~sclk;
      end
      if (w < nw) check("miso_word", got, (spi_en && op == 2 && w > 0) ? rd_model(a + w - 1) : 0);
    end
    if (do_rst) begin
      nreset = 1'b0;
      #1;
      check("reset_mid_frame", outs(), 0);
      @(negedge clk);
      nreset = 1'b1;
    end
    repeat (SETUP) @(negedge clk);
    ss = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  // random fetch pushback
  initial begin
    wait_in = 1'b0;
    forever begin
      @(negedge clk);
      wait_in = $urandom_range(0, 3) == 0;
    end
  end

  // monitor: every DUT output event is matched against the scoreboard queue
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (nreset) begin
        if (reg_write) expect_ev(0, reg_addr, reg_wdata);
        if (reg_read) expect_ev(1, reg_addr, 0);
        if (frame_err) expect_ev(2, 0, 0);
        if (access_out && !acc_prev) expect_ev(3, fetch_addr, 0);
`ifdef SPI_SLAVE_FETCH_EN
        if (acc_prev) begin
          check("access_hold", access_out, wait_in);
          if (wait_in) check("fetch_addr_hold", fetch_addr, fa_prev);
        end
`endif
      end
      if (access_out) acc_seen = 1'b1;
      acc_prev = access_out;
      fa_prev = fetch_addr;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    nreset = 1'b0;
    sclk = 1'b0;
    mosi = 1'b0;
    ss = 1'b1;
    spi_en = 1'b1;
    cpol = 1'b0;
    cpha = 1'b0;
    lsbfirst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 0);
    nreset = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_outputs", outs(), 0);
    set_mode(0, 0);
    fb[0] = 8'h05; fb[1] = 8'hA5; fb[2] = 8'h3C;
    spi_xfer(3, 0, 0);
    set_mode(3, 0);
    fb[0] = 8'h90; fb[1] = 8'h00; fb[2] = 8'hFF;
    spi_xfer(3, 0, 0);
    set_mode(1, 1);
    fb[0] = 8'h3F; fb[1] = 8'h11; fb[2] = 8'h22;
    spi_xfer(3, 0, 0);
    set_mode(0, 0);
    fb[0] = 8'hC7;
    spi_xfer(1, 0, 0);
    fb[0] = 8'h05; fb[1] = 8'hA5; fb[2] = 8'hF0;
    spi_xfer(2, 3, 0);
    fb[0] = 8'h05; fb[1] = 8'hA5;
    spi_xfer(1, 3, 1);
    fb[0] = 8'h02; fb[1] = 8'h77;
    spi_xfer(2, 0, 0);
    spi_en = 1'b0;
    fb[0] = 8'h10; fb[1] = 8'h99;
    spi_xfer(2, 0, 0);
    spi_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int nw, pb;
      set_mode($urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 8; k++) fb[k] = 8'($urandom);
      nw = $urandom_range(0, 4);
      pb = (nw == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      spi_xfer(nw, pb, 0);
    end
    repeat (GAP) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
`ifdef SPI_SLAVE_FETCH_EN
    check("fetch_seen", acc_seen, 1);
`else
    check("fetch_absent", acc_seen, 0);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_sync.md
# spi_slave_sync

Single-clock SPI slave front end that runs entirely in the core clock domain. It oversamples sclk/ss/mosi with synchronizers instead of clocking logic on sclk. It supports all four CPOL/CPHA modes, a parametrised word width and auto-incrementing burst register reads and writes, and it raises a remote fetch request when the frame ends. It sits between the SPI pins and the SPI register file / core fetch logic and replaces the sclk-clocked slave IO.

## Interface
- DW, 8: SPI word width in bits (8, 16 or 32). Command word = DW bits: opcode in [DW-1:DW-2], address in [DW-3:0].
- AW, DW-2: register address width (derived; do not override).
- SYNC, 2: synchronizer depth for sclk/ss/mosi (>=2).

Ports:
- clk  in  1  core clock
- nreset  in  1  asynchronous active-low reset
- sclk / mosi / ss  in  1  SPI pins, asynchronous to clk
- miso  out  1  slave data out
- spi_en / cpol / cpha / lsbfirst  in  1  static control
- reg_write  out  1  one-cycle write strobe
- reg_read  out  1  one-cycle read strobe
- reg_addr  out  AW  register address
- reg_wdata  out  DW  write data
- reg_rdata  in  DW  read data, sampled the cycle after reg_read
- access_out  out  1  fetch request
- fetch_addr  out  AW  address of fetch
- wait_in  in  1  fetch pushback
- frame_err  out  1  one-cycle pulse on truncated frame

## Operation
- Opcodes: 2'b00 WR, 2'b10 RD, 2'b11 FETCH, 2'b01 reserved (frame ignored, no strobes).
- Synchronize sclk, ss and mosi through SYNC flops. Detect sclk edges on the synchronized sclk; mosi is taken from the same pipeline stage.
- Edge roles:
  - Sample edge: rising when cpol^cpha==0, falling otherwise.
  - Drive edge: the opposite edge.
  - cpha=0: first bit is driven when ss falls.
- FSM states: IDLE, CMD, DATA.
  - IDLE -> CMD on synced ss fall with spi_en=1; bit_cnt=0; tx shifter=0.
  - CMD -> DATA after DW samples; latch cmd_reg.
  - Any state -> IDLE on ss rise or spi_en=0.
- bit_cnt: log2(DW) bits, wraps at DW-1 -> 0; a word completes on the sample edge where bit_cnt==DW-1.
- Shift order: lsbfirst=1 shifts LSB first on both rx and tx; otherwise MSB first.
- RD:
  - At CMD completion, pulse reg_read with reg_addr=cmd address.
  - Load reg_rdata into the tx shifter on the next cycle.
  - At each DATA word completion: address+1, next reg_read, reload.
- WR: each complete DATA word pulses reg_write with reg_wdata=rx word and reg_addr=current address, then address+1.
- Address arithmetic is modulo 2^AW (0x3F+1 -> 0x00 for DW=8).
- FETCH:
  - On ss rise after CMD completed with FETCH opcode, set access_out=1 with fetch_addr=cmd address.
  - access_out clears on the first cycle with wait_in=0; it is held along with fetch_addr while wait_in=1.
  - A new fetch arriving while one is pending is dropped.
- ss rise with bit_cnt!=0 in CMD or DATA: discard the partial word (no strobe) and pulse frame_err.
- miso = tx shifter output bit while ss is low and spi_en=1, else 0. miso is 0 throughout CMD.
- spi_en=0: all strobes suppressed, FSM held in IDLE, partial frames aborted without frame_err.

## Timing
- Reset values: state IDLE, miso=0, reg_write=0, reg_read=0, reg_addr=0, reg_wdata=0, access_out=0, fetch_addr=0, frame_err=0.
- Requirement: sclk high and low phases each >= SYNC+2 clk cycles; ss setup to first edge >= SYNC+2 cycles.
- Strobe latency: reg_write/reg_read assert SYNC+2 clk cycles after the raw sclk sample edge.
- miso changes SYNC+2 cycles after the raw drive edge.
- access_out asserts SYNC+2 cycles after raw ss rise.
- Reset mid-frame: everything returns to reset values immediately; the frame is lost, and the next ss fall starts a clean CMD.

## Configuration
- SPI_SLAVE_FETCH_EN defined: FETCH opcode, access_out, fetch_addr and wait_in behave as above.
- Undefined: opcode 2'b11 is treated as reserved; access_out and fetch_addr are tied to 0; wait_in is ignored.

## Test plan
- DW=8, mode 0, MSB first: ss low, send 0x05, 0xA5, 0x3C, ss high -> reg_write at addr 0x05 data 0xA5, then addr 0x06 data 0x3C; no frame_err.
- Mode 3, reg_rdata = addr+0x40: send 0x90 then two dummy bytes -> reg_read at 0x10 and 0x11; miso returns 0x50, 0x51.
- Mode 1, lsbfirst=1: WR cmd 0x3F, data 0x11, 0x22 -> writes at addr 0x3F then 0x00 (wrap).
- FETCH: send 0xC7, ss high with wait_in=1 for 3 cycles -> access_out high 4 cycles, fetch_addr=0x07; macro undefined -> access_out stays 0.
- Truncation: send 0x05, 0xA5, then 3 bits, ss high -> one reg_write (0x05/0xA5) and one frame_err pulse.
- nreset low mid-data-word, then a new WR frame 0x02, 0x77 -> all outputs at reset values; only the write at addr 0x02 data 0x77 occurs.
